// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the configurable UART blocks.
//   parity_t        : line parity selection (reserved code behaves as none)
//   tx_state_t      : transmitter frame states
//   UART_IDLE_LEVEL : level of an idle / stop-bit line
//   parity_bit()    : parity bit for up to 9 data bits
//   parity_on()     : whether a parity mode adds a parity bit to the frame
// Optional feature macro: UART_TX_BREAK_EN (adds the BREAK state).
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Widest data field any UART block in this family supports.
    localparam int UART_MAX_DATA_BITS = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_RSVD = 2'd3
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_BREAK_EN
        , BREAK
`endif
    } tx_state_t;

    // Unused upper bits must be zero; they do not disturb the XOR.
    function automatic logic parity_bit(input logic [UART_MAX_DATA_BITS-1:0] data,
                                        input parity_t                       mode);
        logic p;
        case (mode)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~^data;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

    function automatic logic parity_on(input parity_t mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
// Loadable down-counter with a zero flag. Shared by the UART transmitter and
// receiver to time bit periods.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (wins over counting)
//   load_val   : reload value (period - 1)
//   count      : current count
//   zero       : count == 0; the counter holds at zero until reloaded
// ---------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
// Runtime-configurable UART transmitter: DATA_BITS data bits (5..9), LSB
// first, optional even/odd parity, one or two stop bits, baud divisor taken
// from i_clk_div at accept time. Valid/ready handshake allows back-to-back
// frames with no idle gap.
//
// Parameters: DATA_BITS (5..9), DIV_BITS (divisor width).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_tx_data   : payload, bit 0 sent first
//   i_tx_valid  : payload valid
//   o_tx_ready  : accept happens on an edge where valid & ready
//   i_clk_div   : clocks per bit (0 behaves as 1), latched on accept
//   i_parity    : parity_t code, latched on accept
//   i_two_stop  : 1 = two stop bits, latched on accept
//   i_break     : (UART_TX_BREAK_EN only) hold line low while high
//   o_tx_busy   : frame (or break) in progress
//   o_tx_done   : one-cycle pulse after the final stop bit
//   o_tx_data   : registered serial line, idle high
// Optional feature macro: UART_TX_BREAK_EN.
// ---------------------------------------------------------------------------
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    input  logic [DIV_BITS-1:0]  i_clk_div,
    input  logic [1:0]           i_parity,
    input  logic                 i_two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic                 i_break,
`endif
    output logic                 o_tx_busy,
    output logic                 o_tx_done,
    output logic                 o_tx_data
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [IDX_W-1:0]     bit_idx;
    logic [DIV_BITS-1:0]  div_m1;        // latched D-1
    logic [DIV_BITS-1:0]  div_m1_in;     // D-1 derived from the live input
    logic                 par_en;
    logic                 par_val;
    logic                 two_stop;
    logic                 stop_last;     // current stop bit is the final one
    logic                 tx_line;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx_done;

    logic                 accept;
    logic                 cnt_load;
    logic [DIV_BITS-1:0]  cnt_load_val;
    logic [DIV_BITS-1:0]  cnt;
    logic                 cnt_zero;

    assign accept    = i_tx_valid & tx_ready;
    assign div_m1_in = (i_clk_div == '0) ? '0 : i_clk_div - DIV_BITS'(1);

    // Counter reload: on accept (with the live divisor, since the latched one
    // is being replaced on the same edge) and at every bit boundary.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_load     = accept;
        cnt_load_val = accept ? div_m1_in : div_m1;
        case (state)
            START, DATA, PARITY, STOP: if (cnt_zero) cnt_load = 1'b1;
`ifdef UART_TX_BREAK_EN
            BREAK:                     if (!i_break) cnt_load = 1'b1;
`endif
            default: ;
        endcase
    end

    uart_baud_cnt #(
        .WIDTH   (DIV_BITS)
    ) u_baud_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cnt_load),
        .load_val(cnt_load_val),
        .count   (cnt),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            div_m1    <= '0;
            par_en    <= 1'b0;
            par_val   <= 1'b0;
            two_stop  <= 1'b0;
            stop_last <= 1'b0;
            tx_line   <= UART_IDLE_LEVEL;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (accept) begin
                // Accept from IDLE or from the last clock of a final stop bit;
                // the start bit goes out on this very edge.
                state    <= START;
                shreg    <= i_tx_data;
                bit_idx  <= '0;
                div_m1   <= div_m1_in;
                par_en   <= parity_on(parity_t'(i_parity));
                par_val  <= parity_bit(UART_MAX_DATA_BITS'(i_tx_data), parity_t'(i_parity));
                two_stop <= i_two_stop;
                tx_line  <= 1'b0;
                tx_busy  <= 1'b1;
                tx_ready <= 1'b0;
                tx_done  <= (state == STOP);
            end else begin
                case (state)
                    IDLE: begin
                        tx_ready <= 1'b1;
`ifdef UART_TX_BREAK_EN
                        if (i_break) begin
                            state    <= BREAK;
                            div_m1   <= div_m1_in;
                            tx_line  <= 1'b0;
                            tx_busy  <= 1'b1;
                            tx_ready <= 1'b0;
                        end
`endif
                    end

                    START: begin
                        if (cnt_zero) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            tx_line <= shreg[0];
                        end
                    end

                    DATA: begin
                        if (cnt_zero) begin
                            if (bit_idx == LAST_IDX) begin
                                if (par_en) begin
                                    state   <= PARITY;
                                    tx_line <= par_val;
                                end else begin
                                    state     <= STOP;
                                    tx_line   <= UART_IDLE_LEVEL;
                                    stop_last <= !two_stop;
                                    // With D=1 the first stop clock is already its last.
                                    tx_ready  <= !two_stop && (div_m1 == '0);
                                end
                            end else begin
                                bit_idx <= bit_idx + IDX_W'(1);
                                shreg   <= shreg >> 1;
                                tx_line <= shreg[1];
                            end
                        end
                    end

                    PARITY: begin
                        if (cnt_zero) begin
                            state     <= STOP;
                            tx_line   <= UART_IDLE_LEVEL;
                            stop_last <= !two_stop;
                            tx_ready  <= !two_stop && (div_m1 == '0);
                        end
                    end

                    STOP: begin
                        if (cnt_zero) begin
                            if (stop_last) begin
                                state    <= IDLE;
                                tx_busy  <= 1'b0;
                                tx_ready <= 1'b1;
                                tx_done  <= 1'b1;
`ifdef UART_TX_BREAK_EN
                                if (i_break) begin
                                    state    <= BREAK;
                                    div_m1   <= div_m1_in;
                                    tx_line  <= 1'b0;
                                    tx_busy  <= 1'b1;
                                    tx_ready <= 1'b0;
                                end
`endif
                            end else begin
                                stop_last <= 1'b1;
                                tx_ready  <= (div_m1 == '0);
                            end
                        end else begin
                            // Raise ready one edge early so it is high during
                            // the final clock of the final stop bit.
                            tx_ready <= stop_last && (cnt == DIV_BITS'(1));
                        end
                    end

`ifdef UART_TX_BREAK_EN
                    BREAK: begin
                        // Break ends with one stop-bit period of idle line; the
                        // closing stop period pulses done like a frame end.
                        if (!i_break) begin
                            state     <= STOP;
                            tx_line   <= UART_IDLE_LEVEL;
                            stop_last <= 1'b1;
                            tx_ready  <= (div_m1 == '0);
                        end
                    end
`endif

                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign o_tx_data  = tx_line;
    assign o_tx_ready = tx_ready;
    assign o_tx_busy  = tx_busy;
    assign o_tx_done  = tx_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg
// Self-checking bench for uart_tx_cfg (DATA_BITS=8, DIV_BITS=16). Each frame
// is modelled as a list of line levels (start, data LSB first, parity, stops)
// each lasting D clocks; every clock the line/busy/ready/done outputs are
// compared against that model. Directed frames first, then random ones,
// then an asynchronous reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

    localparam int DB = 8;
    localparam int DW = 16;

    typedef struct {
        logic [7:0] data;
        int         div;
        int         par;
        bit         two;
        bit         b2b;    // next frame is offered on this frame's ready edge
    } frame_t;

    logic          clk;
    logic          rst_n;
    logic [DB-1:0] i_tx_data;
    logic          i_tx_valid;
    logic          o_tx_ready;
    logic [DW-1:0] i_clk_div;
    logic [1:0]    i_parity;
    logic          i_two_stop;
    logic          i_break;
    logic          o_tx_busy;
    logic          o_tx_done;
    logic          o_tx_data;

    int vectors     = 0;
    int miscompares = 0;
    int frame_no    = 0;

    uart_tx_cfg #(
        .DATA_BITS (DB),
        .DIV_BITS  (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_tx_data (i_tx_data),
        .i_tx_valid(i_tx_valid),
        .o_tx_ready(o_tx_ready),
        .i_clk_div (i_clk_div),
        .i_parity  (i_parity),
        .i_two_stop(i_two_stop),
`ifdef UART_TX_BREAK_EN
        .i_break   (i_break),
`endif
        .o_tx_busy (o_tx_busy),
        .o_tx_done (o_tx_done),
        .o_tx_data (o_tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: line/busy/ready/done got %b expected %b", tag, got[3:0], exp[3:0]);
        end
    endtask

    function automatic logic [3:0] outs();
        return {o_tx_data, o_tx_busy, o_tx_ready, o_tx_done};
    endfunction

    task automatic drive(input frame_t f);
        i_tx_data  = f.data;
        i_clk_div  = DW'(f.div);
        i_parity   = 2'(f.par);
        i_two_stop = f.two;
        i_tx_valid = 1'b1;
    endtask

    // Garbage on every input while the block is busy; none of it may matter.
    task automatic scramble();
        i_tx_valid = 1'($urandom_range(0, 1));
        i_tx_data  = DB'($urandom);
        i_clk_div  = DW'($urandom);
        i_parity   = 2'($urandom_range(0, 3));
        i_two_stop = 1'($urandom_range(0, 1));
    endtask

    // Called at the negedge just before the accepting edge (frame already driven).
    task automatic run_frame(input frame_t c, input bit prev_b2b,
                             input bit has_next, input frame_t nx);
        bit   lvl[$];
        int   d_eff;
        int   n;
        int   idle;
        bit   go_b2b;
        logic p;
        d_eff  = (c.div == 0) ? 1 : c.div;
        go_b2b = has_next && c.b2b;
        p      = ^c.data;
        lvl.push_back(1'b0);
        for (int i = 0; i < DB; i++) lvl.push_back(c.data[i]);
        if (c.par == 1) lvl.push_back(p);
        if (c.par == 2) lvl.push_back(~p);
        lvl.push_back(1'b1);
        if (c.two) lvl.push_back(1'b1);
        n = d_eff * lvl.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check($sformatf("frame%0d cyc%0d", frame_no, k), 32'(outs()),
                  32'({lvl[k / d_eff], 1'b1, (k == n - 1), (k == 0) && prev_b2b}));
            if (k == 0) scramble();
            if (k == n - 1) begin
                if (go_b2b) drive(nx);
                else        i_tx_valid = 1'b0;
            end
        end
        frame_no++;
        if (!go_b2b) begin
            @(negedge clk);
            check($sformatf("frame%0d done", frame_no - 1), 32'(outs()), 32'(4'b1011));
            idle = $urandom_range(0, 2);
            repeat (idle) begin
                @(negedge clk);
                check($sformatf("frame%0d idle", frame_no - 1), 32'(outs()), 32'(4'b1010));
            end
            if (has_next) drive(nx);
        end
    endtask

    frame_t frames[$];
    frame_t f;
    frame_t none;

    initial begin
        rst_n      = 1'b0;
        i_tx_data  = '0;
        i_tx_valid = 1'b0;
        i_clk_div  = '0;
        i_parity   = '0;
        i_two_stop = 1'b0;
        i_break    = 1'b0;
        none       = '{8'h00, 1, 0, 1'b0, 1'b0};

        // Directed frames.
        frames.push_back('{8'h55, 4, 0, 1'b0, 1'b0});   // 8n1, D=4, 40 clocks
        frames.push_back('{8'h07, 3, 1, 1'b0, 1'b0});   // even parity -> 1
        frames.push_back('{8'h07, 3, 2, 1'b0, 1'b0});   // odd parity  -> 0
        frames.push_back('{8'hA5, 2, 0, 1'b1, 1'b1});   // two stops, back-to-back
        frames.push_back('{8'h3C, 2, 0, 1'b1, 1'b0});
        frames.push_back('{8'h96, 0, 0, 1'b0, 1'b1});   // divisor 0 acts as 1
        frames.push_back('{8'h69, 1, 3, 1'b0, 1'b0});   // reserved parity = none
        // Random frames.
        for (int i = 0; i < 40; i++) begin
            f.data = 8'($urandom);
            f.div  = $urandom_range(0, 5);
            f.par  = $urandom_range(0, 3);
            f.two  = 1'($urandom_range(0, 1));
            f.b2b  = 1'($urandom_range(0, 1));
            frames.push_back(f);
        end

        // Reset state and ready rising on the first edge after release.
        repeat (3) begin
            @(negedge clk);
            check("reset", 32'(outs()), 32'(4'b1000));
        end
        rst_n = 1'b1;
        check("release", 32'(outs()), 32'(4'b1000));
        @(negedge clk);
        check("ready_after_release", 32'(outs()), 32'(4'b1010));

        drive(frames[0]);
        for (int i = 0; i < frames.size(); i++) begin
            run_frame(frames[i], (i > 0) && frames[i-1].b2b,
                      i + 1 < frames.size(),
                      (i + 1 < frames.size()) ? frames[i+1] : none);
        end

        // Asynchronous reset in the middle of the data bits.
        drive('{8'h55, 2, 0, 1'b0, 1'b0});
        @(posedge clk);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset", 32'(outs()), 32'(4'b1000));
        i_tx_valid = 1'b0;
        @(negedge clk);
        check("in_reset", 32'(outs()), 32'(4'b1000));
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_abort", 32'(outs()), 32'(4'b1010));
        f = '{8'hFF, 3, 2, 1'b0, 1'b0};
        drive(f);
        run_frame(f, 1'b0, 1'b0, none);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter that supersedes the fixed 8n1 transmitter. It supports 5-9 data bits, selectable parity and 1 or 2 stop bits, sends LSB first, and takes its baud divisor from a runtime input. It uses a valid/ready byte handshake so an upstream FIFO or message sequencer can stream frames back-to-back with no idle gap.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
DIV_BITS, 16, width of the runtime baud divisor.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_tx_data  in  DATA_BITS  payload; bit 0 is sent first
i_tx_valid  in  1  payload valid
o_tx_ready  out  1  block accepts the payload on this edge when i_tx_valid=1
i_clk_div  in  DIV_BITS  clocks per bit; 0 is treated as 1
i_parity  in  2  parity_t: 0 none, 1 even, 2 odd, 3 reserved (treated as none)
i_two_stop  in  1  0 = one stop bit, 1 = two stop bits
o_tx_busy  out  1  frame in progress
o_tx_done  out  1  one-cycle pulse at frame end
o_tx_data  out  1  serial line, idle high, registered

Behaviour:
- Reset: one clock and async active-low reset (rst_n). While rst_n=0: o_tx_data=1, o_tx_ready=0, o_tx_busy=0, o_tx_done=0, state=IDLE.
  - Asserting rst_n mid-frame aborts the frame and forces the line high immediately.
  - o_tx_ready rises on the first clk edge after rst_n deasserts.
- States (tx_state_t): IDLE, START, DATA, PARITY, STOP.
- Accept on a clk edge with i_tx_valid & o_tx_ready. On that edge, latch i_tx_data, i_clk_div (0→1), i_parity and i_two_stop.
  - Config inputs are ignored at all other times. Changing them mid-frame has no effect.
- Latency: o_tx_data goes 0 (start bit) on the accepting edge itself. No extra idle cycle.
- Every bit lasts exactly D latched clocks, driven by a down-counter reloaded to D-1 at each bit boundary.
- Transitions:
  - START → DATA.
  - DATA sends DATA_BITS bits, LSB first.
  - DATA → PARITY if parity is even/odd, else DATA → STOP.
  - PARITY → STOP.
  - STOP lasts 1×D or 2×D clocks, then → IDLE.
- Parity bit: even = XOR of the data bits; odd = inverted XOR.
- Frame length in clocks = D × (1 + DATA_BITS + P + S), where P ∈ {0,1} and S ∈ {1,2}.
- o_tx_ready is 1 in IDLE and also during the last clock of the final stop bit. This allows back-to-back frames: an accept on that edge goes straight to START.
- o_tx_busy is 1 from the clock after accept until the end of the final stop bit; 0 in IDLE.
- o_tx_done pulses for exactly one cycle, in the cycle after the final stop bit completes. It also pulses when a back-to-back accept occurs on that edge.
- i_tx_valid deasserted while o_tx_ready=0 is legal and ignored; there is no abort input.
- Counter widths: bit counter $clog2(DATA_BITS) bits; clock counter DIV_BITS bits. No wrap occurs for any legal D up to 2^DIV_BITS-1.

Optional Feature:
- Macro UART_TX_BREAK_EN.
- Defined: adds input i_break (1 bit) and state BREAK.
  - i_break=1 sampled in IDLE (or at the ready edge with no valid) enters BREAK.
  - In BREAK: o_tx_data=0, o_tx_ready=0, o_tx_busy=1.
  - When i_break falls: one full stop-bit period D of line high, then IDLE.
  - If valid and break are both present at an accept edge, the data frame wins.
- Undefined: no i_break port and no BREAK state; behaviour exactly as above.

Decomposition:
- Package uart_pkg holds:
  - parity_t enum
  - tx_state_t enum
  - constant UART_IDLE_LEVEL = 1'b1
  - function parity_bit(data, mode)
- Sub-module uart_baud_cnt: loadable down-counter with a zero flag, DIV_BITS wide, reused by the future receiver.

Test Plan:
- DATA_BITS=8, D=4, parity none, 1 stop, send 0x55 → line 0,1,0,1,0,1,0,1,0,1, each bit 4 clocks; 40-clock frame; one o_tx_done pulse.
- D=3, even parity, send 0x07 → parity bit 1. Odd parity, send 0x07 → parity bit 0. Frame = 33 clocks.
- i_two_stop=1, D=2, valid held high with 0xA5 then 0x3C → two stop bits (4 clocks high), then the next start bit with zero idle clocks between frames.
- i_clk_div=0 → behaves identically to D=1; 10-clock frame for 8n1.
- rst_n asserted in the middle of DATA → o_tx_data=1 asynchronously and busy=0. After release, ready=1 on the first edge, and a new frame of 0xFF is sent correctly.
- UART_TX_BREAK_EN defined: hold i_break for 50 clocks with D=4 → line low 50 clocks, then high 4 clocks, then ready=1.
